// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported synchronous memory between an
// instruction-fetch port (if), a data port (dm) and an external debug read
// port (ex). Each access takes three cycles: IDLE (arbitrate), ISSUE
// (strobe the memory), RESP (read data arrives, captured on the way back
// to IDLE). The ack pulse appears in the IDLE cycle that follows RESP.
//
// Optional feature: define MEM_ARB_DEBUG_PORT_EN to enable the ex port and
// its starvation counter. Without it, ex_* inputs are ignored and ex_ack /
// ex_data_out read as zero.
//
//   state | meaning
//   IDLE  | waiting; arbitrate among eligible requesters
//   ISSUE | mem_en high, registered address/we/wdata presented
//   RESP  | mem_rdata valid; capture into winner's register, ack next cycle

module mem_port_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_ack,
    output logic [31:0]       if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [31:0]       dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic              dm_ack,
    output logic [31:0]       dm_rdata,
    input  logic              ex_req,
    input  logic [31:0]       ex_addr,
    output logic              ex_ack,
    output logic [31:0]       ex_data_out,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    typedef enum logic [1:0] {WIN_IF, WIN_DM, WIN_EX} win_t;

    state_t            state_q;
    win_t              win_q;
    win_t              sel_d;
    logic              grant_d;
    logic              store_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [31:0]       mem_wdata_q;
    logic              if_ack_q;
    logic              dm_ack_q;
    logic [31:0]       if_rdata_q;
    logic [31:0]       dm_rdata_q;
    logic              if_elig;
    logic              dm_elig;
    logic              ex_elig;
    logic              ex_starved;

    // Byte-address bits outside the word index carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{if_addr, dm_addr, ex_addr, ex_req};

`ifdef MEM_ARB_DEBUG_PORT_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt_q;
    logic             ex_ack_q;
    logic [31:0]      ex_data_q;
    logic             ex_owns;

    assign ex_elig    = ex_req && !ex_ack_q;
    assign ex_starved = ex_elig && (starve_cnt_q == CNT_W'(STARVE_LIMIT));
    // ex is "being served" from grant through its ack cycle; no ageing then.
    assign ex_owns    = ((state_q != IDLE) && (win_q == WIN_EX)) || ex_ack_q;

    // Starvation age of a waiting ex request; cleared when ex is granted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else if (state_q == IDLE && grant_d && sel_d == WIN_EX) begin
            starve_cnt_q <= '0;
        end else if (ex_req && !ex_owns && starve_cnt_q != CNT_W'(STARVE_LIMIT)) begin
            starve_cnt_q <= starve_cnt_q + 1'b1;
        end
    end

    assign ex_ack      = ex_ack_q;
    assign ex_data_out = ex_data_q;
`else
    assign ex_elig     = 1'b0;
    assign ex_starved  = 1'b0;
    assign ex_ack      = 1'b0;
    assign ex_data_out = '0;
`endif

    assign if_elig = if_req && !if_ack_q;
    assign dm_elig = dm_req && !dm_ack_q;

    // Fixed priority pick: starved ex, dm, if, then ex.
    always_comb begin
        grant_d = 1'b1;
        sel_d   = WIN_IF;
        addr_d  = if_addr[ADDR_W+1:2];
        if (ex_starved) begin
            sel_d  = WIN_EX;
            addr_d = ex_addr[ADDR_W+1:2];
        end else if (dm_elig) begin
            sel_d  = WIN_DM;
            addr_d = dm_addr[ADDR_W+1:2];
        end else if (if_elig) begin
            sel_d  = WIN_IF;
            addr_d = if_addr[ADDR_W+1:2];
        end else if (ex_elig) begin
            sel_d  = WIN_EX;
            addr_d = ex_addr[ADDR_W+1:2];
        end else begin
            grant_d = 1'b0;
        end
    end

    // Transaction FSM with registered memory strobes, acks and read data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            win_q       <= WIN_IF;
            store_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
`ifdef MEM_ARB_DEBUG_PORT_EN
            ex_ack_q    <= 1'b0;
            ex_data_q   <= '0;
`endif
        end else begin
            if_ack_q <= 1'b0;
            dm_ack_q <= 1'b0;
`ifdef MEM_ARB_DEBUG_PORT_EN
            ex_ack_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        state_q     <= ISSUE;
                        win_q       <= sel_d;
                        store_q     <= (sel_d == WIN_DM) && dm_we;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= (sel_d == WIN_DM) && dm_we;
                        mem_addr_q  <= addr_d;
                        mem_wdata_q <= (sel_d == WIN_DM) ? dm_wdata : '0;
                    end
                end
                ISSUE: begin
                    state_q  <= RESP;
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                end
                RESP: begin
                    state_q <= IDLE;
                    case (win_q)
                        WIN_IF: begin
                            if_ack_q   <= 1'b1;
                            if_rdata_q <= mem_rdata;
                        end
                        WIN_DM: begin
                            dm_ack_q <= 1'b1;
                            if (!store_q) dm_rdata_q <= mem_rdata;
                        end
`ifdef MEM_ARB_DEBUG_PORT_EN
                        WIN_EX: begin
                            ex_ack_q  <= 1'b1;
                            ex_data_q <= mem_rdata;
                        end
`endif
                        default: ;
                    endcase
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign if_ack    = if_ack_q;
    assign if_rdata  = if_rdata_q;
    assign dm_ack    = dm_ack_q;
    assign dm_rdata  = dm_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a one-cycle-latency memory model.
// Honors MEM_ARB_DEBUG_PORT_EN: runs the starvation scenario when defined,
// the ex-ignored scenario otherwise.

module tb_mem_port_arbiter;

    localparam int ADDR_W = 10;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              if_req = 1'b0;
    logic [31:0]       if_addr = '0;
    logic              if_ack;
    logic [31:0]       if_rdata;
    logic              dm_req = 1'b0;
    logic              dm_we = 1'b0;
    logic [31:0]       dm_addr = '0;
    logic [31:0]       dm_wdata = '0;
    logic              dm_ack;
    logic [31:0]       dm_rdata;
    logic              ex_req = 1'b0;
    logic [31:0]       ex_addr = '0;
    logic              ex_ack;
    logic [31:0]       ex_data_out;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = '0;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(8)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .ex_req(ex_req), .ex_addr(ex_addr), .ex_ack(ex_ack), .ex_data_out(ex_data_out),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clock = ~clock;

    // Memory model: fixed initial contents, overlaid by words written so far.
    logic [31:0] mem_wr [0:1023];
    bit          mem_wr_valid [0:1023];

    function automatic logic [31:0] init_word(input int a);
        case (a)
            2:       return 32'h1111_2222;
            3:       return 32'h3333_0003;
            4:       return 32'h2008_0005;
            32'h20:  return 32'hE0E0_0020;
            32'h30:  return 32'h5555_AAAA;
            default: return 32'h0BAD_0000 | a;
        endcase
    endfunction

    function automatic logic [31:0] rd_word(input int a);
        return mem_wr_valid[a] ? mem_wr[a] : init_word(a);
    endfunction

    always @(posedge clock) begin
        if (mem_en) begin
            mem_rdata <= rd_word(int'(mem_addr));
            if (mem_we) begin
                mem_wr[mem_addr]       <= mem_wdata;
                mem_wr_valid[mem_addr] <= 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int dm_c;
        int if_c;
        int ex_c;
        int nack;

        // Reset values
        #3;
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_acks", {if_ack, dm_ack, ex_ack}, 0);
        check("rst_rdata", if_rdata | dm_rdata | ex_data_out, 0);
        check("rst_busy", busy, 0);
        #9 reset = 1'b0;
        step();

        // Single fetch: cycle 0 request
        if_req = 1'b1; if_addr = 32'h0000_0010;
        step();
        check("fetch_c1_mem_en", mem_en, 1);
        check("fetch_c1_mem_addr", mem_addr, 4);
        check("fetch_c1_mem_we", mem_we, 0);
        check("fetch_c1_busy", busy, 1);
        step();
        check("fetch_c2_mem_en", mem_en, 0);
        check("fetch_c2_ack", if_ack, 0);
        step();
        check("fetch_c3_ack", if_ack, 1);
        check("fetch_c3_rdata", if_rdata, 32'h2008_0005);
        check("fetch_c3_busy", busy, 0);
        if_req = 1'b0;
        step();
        check("fetch_c4_ack", if_ack, 0);

        // Conflict: dm (load 0x08) and if (0x0C) together at cycle 0
        if_req = 1'b1; if_addr = 32'h0000_000C;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0008;
        for (int c = 1; c <= 8; c++) begin
            step();
            check($sformatf("conf_c%0d_dm_ack", c), dm_ack, (c == 3));
            check($sformatf("conf_c%0d_if_ack", c), if_ack, (c == 6));
            if (dm_ack) begin
                check("conf_dm_rdata", dm_rdata, 32'h1111_2222);
                dm_req = 1'b0;
            end
            if (if_ack) begin
                check("conf_if_rdata", if_rdata, 32'h3333_0003);
                if_req = 1'b0;
            end
        end

        // Store 0xDEADBEEF to byte 0x40; dm_rdata must keep the last load value
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEAD_BEEF;
        step();
        check("st_mem_en", mem_en, 1);
        check("st_mem_we", mem_we, 1);
        check("st_mem_addr", mem_addr, 32'h10);
        check("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        step();
        step();
        check("st_ack", dm_ack, 1);
        check("st_rdata_kept", dm_rdata, 32'h1111_2222);
        check("st_mem_word", rd_word(32'h10), 32'hDEAD_BEEF);
        dm_req = 1'b0; dm_we = 1'b0;
        step();

        // Load back byte 0x40
        dm_req = 1'b1; dm_addr = 32'h40;
        step();
        check("ld_mem_we", mem_we, 0);
        check("ld_mem_addr", mem_addr, 32'h10);
        step();
        step();
        check("ld_ack", dm_ack, 1);
        check("ld_rdata", dm_rdata, 32'hDEAD_BEEF);
        dm_req = 1'b0;
        step();

`ifdef MEM_ARB_DEBUG_PORT_EN
        // Starvation: if/dm held continuously, ex reads byte 0x80
        if_req = 1'b1; if_addr = 32'h10;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h08;
        ex_req = 1'b1; ex_addr = 32'h80;
        ex_c = -1;
        for (int c = 1; c <= 30 && ex_c < 0; c++) begin
            step();
            nack = int'(if_ack) + int'(dm_ack) + int'(ex_ack);
            check($sformatf("starve_c%0d_one_ack", c), (nack <= 1), 1);
            if (ex_ack) ex_c = c;
        end
        check("starve_ex_ack_cycle", ex_c, 12);
        check("starve_ex_data", ex_data_out, 32'hE0E0_0020);
        ex_req = 1'b0; if_req = 1'b0; dm_req = 1'b0;
        for (int c = 0; c < 6; c++) step();
        check("starve_drained_busy", busy, 0);
`else
        // Debug port compiled out: ex requests must be ignored entirely
        ex_req = 1'b1; ex_addr = 32'h80;
        for (int c = 0; c < 50; c++) begin
            step();
            check($sformatf("exoff_c%0d_ack", c), ex_ack, 0);
            check($sformatf("exoff_c%0d_data", c), ex_data_out, 0);
            check($sformatf("exoff_c%0d_busy", c), busy, 0);
        end
        ex_req = 1'b0;
        step();
`endif

        // Reset during the ISSUE cycle of a store to byte 0xC0 (word 0x30)
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'hC0; dm_wdata = 32'h1234_5678;
        step();
        check("rmid_issue_en", mem_en, 1);
        #2 reset = 1'b1;
        #1;
        check("rmid_mem_en", mem_en, 0);
        check("rmid_mem_we", mem_we, 0);
        check("rmid_mem_addr", mem_addr, 0);
        check("rmid_acks", {if_ack, dm_ack, ex_ack}, 0);
        check("rmid_rdata", if_rdata | dm_rdata | ex_data_out, 0);
        check("rmid_busy", busy, 0);
        dm_req = 1'b0; dm_we = 1'b0;
        step();
        reset = 1'b0;
        step();
        check("rmid_word_kept", rd_word(32'h30), 32'h5555_AAAA);
        check("rmid_idle_busy", busy, 0);
        dm_c = 0;
        if_c = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            dm_c += int'(dm_ack);
            if_c += int'(mem_en);
        end
        check("rmid_no_ack", dm_c, 0);
        check("rmid_no_mem_en", if_c, 0);

        // Fresh fetch after reset still works
        if_req = 1'b1; if_addr = 32'h0000_0013;
        step();
        check("post_rst_mem_addr", mem_addr, 4);
        step();
        step();
        check("post_rst_ack", if_ack, 1);
        check("post_rst_rdata", if_rdata, 32'h2008_0005);
        if_req = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
